// File: rtl/bmp280_sample_sched_if.sv
// Avalon-MM register bus plus BMP280 reader handshake for the sample scheduler.
interface bmp280_sample_sched_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        meas_req;
  logic        meas_ack;
  logic        meas_done;
  logic [23:0] adc_p_in;
  logic [23:0] adc_t_in;
  logic        irq;

  modport slave (
    input  address, write, writedata, meas_ack, meas_done, adc_p_in, adc_t_in,
    output readdata, meas_req, irq
  );

  modport master (
    output address, write, writedata, meas_ack, meas_done, adc_p_in, adc_t_in,
    input  readdata, meas_req, irq
  );
endinterface

// File: rtl/bmp280_sample_sched.sv
// Periodic / one-shot BMP280 sample scheduler with an Avalon-MM register file,
// request timeout and level interrupt.
module bmp280_sample_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input logic                   clk,
  input logic                   reset_n,
  bmp280_sample_sched_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StCapture} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        enable_q, irq_en_q;
  logic [31:0] period_q;
  logic        data_valid_q, timeout_q;
  logic [23:0] adc_p_q, adc_t_q, hold_p_q, hold_t_q;
  logic [15:0] count_q;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q;

  logic        wr_ctrl, wr_period, wr_status, oneshot;
  logic [31:0] period_eff;
  logic        period_hit, tmo_hit, busy;
  logic        capture, timeout_set, done_take;

  assign wr_ctrl    = bus.write && (bus.address == 3'd0);
  assign wr_period  = bus.write && (bus.address == 3'd1);
  assign wr_status  = bus.write && (bus.address == 3'd2);
  assign oneshot    = wr_ctrl && bus.writedata[1];
  assign period_eff = (period_q == 32'd0) ? 32'd1 : period_q;
  assign period_hit = enable_q && (pcnt_q == period_eff - 32'd1);
  assign tmo_hit    = (tcnt_q == TIMEOUT_CYCLES - 1);
  assign busy       = (state_q != StIdle);
  assign done_take  = (state_q == StWait) && bus.meas_done && !tmo_hit;

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    tcnt_d      = tcnt_q;
    capture     = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        tcnt_d = '0;
        if (oneshot || period_hit) begin
          pcnt_d  = '0;
          state_d = StReq;
        end else if (enable_q) begin
          pcnt_d = pcnt_q + 32'd1;
        end else begin
          pcnt_d = '0;
        end
      end
      StReq: begin
        if (tmo_hit) begin
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
          if (bus.meas_ack) state_d = StWait;
        end
      end
      StWait: begin
        if (tmo_hit) begin
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
          if (bus.meas_done) state_d = StCapture;
        end
      end
      StCapture: begin
        capture = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (wr_period) pcnt_d = '0;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      3'd0:    readdata_d = {29'd0, irq_en_q, 1'b0, enable_q};
      3'd1:    readdata_d = period_q;
      3'd2:    readdata_d = {29'd0, timeout_q, data_valid_q, busy};
      3'd3:    readdata_d = {8'd0, adc_p_q};
      3'd4:    readdata_d = {8'd0, adc_t_q};
      3'd5:    readdata_d = {16'd0, count_q};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pcnt_q       <= '0;
      tcnt_q       <= '0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      period_q     <= DEFAULT_PERIOD;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      adc_p_q      <= '0;
      adc_t_q      <= '0;
      hold_p_q     <= '0;
      hold_t_q     <= '0;
      count_q      <= '0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      tcnt_q     <= tcnt_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_en_q & (data_valid_q | timeout_q);
      if (wr_ctrl) begin
        enable_q <= bus.writedata[0];
        irq_en_q <= bus.writedata[2];
      end
      if (wr_period) period_q <= bus.writedata;
      if (done_take) begin
        hold_p_q <= bus.adc_p_in;
        hold_t_q <= bus.adc_t_in;
      end
      // Hardware set beats a same-cycle write-1-clear.
      if (capture) begin
        adc_p_q      <= hold_p_q;
        adc_t_q      <= hold_t_q;
        count_q      <= count_q + 16'd1;
        data_valid_q <= 1'b1;
      end else if (wr_status && bus.writedata[1]) begin
        data_valid_q <= 1'b0;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end else if (wr_status && bus.writedata[2]) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.meas_req = (state_q == StReq);
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_bmp280_sample_sched.sv
// Randomized self-checking bench for bmp280_sample_sched against a transaction-level model.
module tb_bmp280_sample_sched;
  localparam int unsigned Tmo       = 16;
  localparam int unsigned DefPeriod = 1000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  bmp280_sample_sched_if bus ();

  bmp280_sample_sched #(
    .TIMEOUT_CYCLES (Tmo),
    .DEFAULT_PERIOD (DefPeriod)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected register contents, updated from observed transactions.
  logic [23:0] exp_p, exp_t;
  logic [15:0] exp_count;
  logic        exp_dv, exp_to, exp_en, exp_irq_en;
  logic [31:0] exp_period;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_p = '0; exp_t = '0; exp_count = '0; exp_dv = 1'b0; exp_to = 1'b0;
    exp_en = 1'b0; exp_irq_en = 1'b0; exp_period = DefPeriod;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    if (a == 3'd0) begin exp_en = d[0]; exp_irq_en = d[2]; end
    if (a == 3'd1) exp_period = d;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    @(negedge clk);
    check(tag, bus.readdata, exp);
  endtask

  task automatic rd_all(input string pfx);
    rd({pfx, "_ctrl"},   3'd0, {29'd0, exp_irq_en, 1'b0, exp_en});
    rd({pfx, "_period"}, 3'd1, exp_period);
    rd({pfx, "_status"}, 3'd2, {29'd0, exp_to, exp_dv, 1'b0});
    rd({pfx, "_adc_p"},  3'd3, {8'd0, exp_p});
    rd({pfx, "_adc_t"},  3'd4, {8'd0, exp_t});
    rd({pfx, "_count"},  3'd5, {16'd0, exp_count});
  endtask

  // Acts as the bus reader for one measurement; gap = idle negedges before meas_req.
  task automatic serve(input int ack_dly, input int done_dly, input bit mid_oneshot,
                       input logic [23:0] p, input logic [23:0] t, output int gap);
    int n = 0;
    int reqc = 0;
    while (bus.meas_req !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    gap = n;
    check("req_start", {31'd0, bus.meas_req}, 32'd1);
    if (bus.meas_req !== 1'b1) return;
    repeat (ack_dly) begin
      if (bus.meas_req) reqc++;
      @(negedge clk);
    end
    if (bus.meas_req) reqc++;
    bus.meas_ack = 1'b1;
    @(negedge clk);
    bus.meas_ack = 1'b0;
    check("req_len", reqc, ack_dly + 1);
    check("req_drop", {31'd0, bus.meas_req}, 32'd0);
    for (int i = 1; i < done_dly; i++) begin
      if (mid_oneshot && i == 1) begin
        bus.address = 3'd0; bus.writedata = {29'd0, exp_irq_en, 1'b1, exp_en}; bus.write = 1'b1;
      end else begin
        bus.write = 1'b0;
      end
      @(negedge clk);
    end
    bus.write = 1'b0;
    bus.adc_p_in = p; bus.adc_t_in = t; bus.meas_done = 1'b1;
    @(negedge clk);
    bus.meas_done = 1'b0;
    bus.adc_p_in = 24'($urandom); bus.adc_t_in = 24'($urandom);
    exp_p = p; exp_t = t; exp_count = exp_count + 16'd1; exp_dv = 1'b1;
  endtask

  task automatic count_req(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      if (bus.meas_req) c++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_meas_req", {31'd0, bus.meas_req}, 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int gap, c, pv, k;
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0;
    bus.meas_ack = 1'b0; bus.meas_done = 1'b0; bus.adc_p_in = '0; bus.adc_t_in = '0;
    model_reset();
    #2;
    do_reset();
    rd_all("reset");
    rd("addr6", 3'd6, 32'd0);
    rd("addr7", 3'd7, 32'd0);

    // Fixed-value periodic run, PERIOD=4.
    wr(3'd1, 32'd4);
    wr(3'd0, 32'h5);
    serve(2, 5, 1'b0, 24'h5A1234, 24'h7E0011, gap);
    for (int i = 0; i < 3; i++) begin
      serve(2, 5, 1'b0, 24'h5A1234, 24'h7E0011, gap);
      check("p4_gap", gap, 5);
    end
    wr(3'd0, 32'h4);
    rd_all("p4");
    check("p4_irq", {31'd0, bus.irq}, 32'd1);

    // Randomized periodic phases; phase 0 uses PERIOD=0.
    for (int ph = 0; ph < 4; ph++) begin
      pv = (ph == 0) ? 0 : int'($urandom_range(0, 6));
      k  = int'($urandom_range(2, 4));
      wr(3'd1, pv);
      wr(3'd0, {29'd0, 1'($urandom), 2'b01});
      for (int i = 0; i < k; i++) begin
        serve(int'($urandom_range(0, 4)), int'($urandom_range(1, 8)), 1'b0,
              24'($urandom), 24'($urandom), gap);
        if (i > 0) check("rnd_gap", gap, ((pv == 0) ? 1 : pv) + 1);
      end
      wr(3'd0, {29'd0, exp_irq_en, 2'b00});
      count_req(6, c);
      check("rnd_stop", c, 0);
      rd_all("rnd");
    end

    // One-shot with enable off, plus an ignored one-shot during WAIT.
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h2);
    exp_dv = 1'b0;
    wr(3'd0, 32'h2);
    serve(1, 4, 1'b1, 24'($urandom), 24'($urandom), gap);
    count_req(20, c);
    check("oneshot_single", c, 0);
    rd_all("oneshot");

    // Reader never acks: timeout after Tmo cycles of meas_req.
    wr(3'd2, 32'h2);
    exp_dv = 1'b0;
    wr(3'd0, 32'h6);
    c = 0;
    while (bus.meas_req && c < 100) begin c++; @(negedge clk); end
    check("tmo_len", c, Tmo);
    exp_to = 1'b1;
    rd("tmo_status", 3'd2, 32'h4);
    rd("tmo_adc_p", 3'd3, {8'd0, exp_p});
    check("tmo_irq", {31'd0, bus.irq}, 32'd1);
    wr(3'd2, 32'h4);
    exp_to = 1'b0;
    @(negedge clk);
    check("tmo_irq_clr", {31'd0, bus.irq}, 32'd0);

    // COUNT wrap, with a write-1-clear of data_valid landing in the CAPTURE cycle.
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    exp_count = 16'hFFFF;
    wr(3'd0, 32'h6);
    serve(0, 3, 1'b0, 24'($urandom), 24'($urandom), gap);
    wr(3'd2, 32'h2);
    rd_all("wrap");
    check("wrap_irq", {31'd0, bus.irq}, 32'd1);

    // Reset while in REQ drops meas_req at once.
    wr(3'd0, 32'h2);
    check("req_before_rst", {31'd0, bus.meas_req}, 32'd1);
    do_reset();

    // Reset during WAIT, then a stale meas_done after release.
    wr(3'd0, 32'h2);
    bus.meas_ack = 1'b1;
    @(negedge clk);
    bus.meas_ack = 1'b0;
    @(negedge clk);
    do_reset();
    bus.adc_p_in = 24'h123456; bus.adc_t_in = 24'h654321; bus.meas_done = 1'b1;
    @(negedge clk);
    bus.meas_done = 1'b0;
    count_req(5, c);
    check("post_rst_req", c, 0);
    rd_all("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
